mac_vector_feeder: RTL and testbench

Upstream operand sequencer for `part2_mac`. Holds two small signed-8-bit operand vectors (A and B) loaded over a simple write port. On `start`, it clears the MAC accumulator and streams `len` element pairs into the MAC's `a`/`b`/`valid_in` inputs, one pair per cycle. It pulses `done` on the exact cycle the MAC's `f` holds the finished dot product.

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_operand_ram.sv | 38 +++
 rtl/mac_vector_feeder.sv | 127 ++++++++++++
 tb/tb_mac_vector_feeder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and FSM state type for the MAC operand feeder.
package mac_pkg;

  localparam int unsigned MAC_DATA_W   = 8;
  localparam int unsigned MAC_ACC_W    = 16;
  localparam int unsigned DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    STREAM,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/mac_operand_ram.sv
// Two-bank DEPTH x 8 operand register file: one banked write port,
// combinational reads of both banks on a shared index, async clear.
module mac_operand_ram
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         wr_en_i,
  input  logic                         wr_sel_i,
  input  logic [AW-1:0]                wr_addr_i,
  input  logic signed [MAC_DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]                rd_idx_i,
  output logic signed [MAC_DATA_W-1:0] rd_a_o,
  output logic signed [MAC_DATA_W-1:0] rd_b_o
);

  logic signed [MAC_DATA_W-1:0] bank_a_q [DEPTH];
  logic signed [MAC_DATA_W-1:0] bank_b_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bank_a_q[i] <= '0;
        bank_b_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      if (wr_sel_i) bank_b_q[wr_addr_i] <= wr_data_i;
      else          bank_a_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_a_o = bank_a_q[rd_idx_i];
  assign rd_b_o = bank_b_q[rd_idx_i];

endmodule

// File: rtl/mac_vector_feeder.sv
// Operand sequencer for part2_mac: clears the MAC, streams len pairs, pulses done
// when f is final. MAC_FEEDER_ZERO_SKIP_EN suppresses valid for zero operands.
module mac_vector_feeder
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ld_en,
  input  logic                         ld_sel,
  input  logic [AW-1:0]                ld_addr,
  input  logic signed [MAC_DATA_W-1:0] ld_data,
  input  logic                         start,
  input  logic [AW:0]                  len,
  output logic signed [MAC_DATA_W-1:0] a,
  output logic signed [MAC_DATA_W-1:0] b,
  output logic                         valid_out,
  output logic                         mac_clr,
  output logic                         busy,
  output logic                         done
);

  localparam logic [AW:0] DEPTH_L    = (AW+1)'(DEPTH);
  localparam logic [1:0]  DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  feeder_state_t                state_q;
  logic [AW:0]                  len_q;
  logic [AW:0]                  idx_q;
  logic [1:0]                   drain_q;
  logic signed [MAC_DATA_W-1:0] a_q, b_q;
  logic                         valid_q, mac_clr_q, busy_q, done_q;

  logic                         wr_en;
  logic [AW:0]                  len_sat;
  logic signed [MAC_DATA_W-1:0] rd_a, rd_b;
  logic                         elem_ok;

  // The done cycle is already IDLE, so writes are additionally masked by done_q.
  assign wr_en   = ld_en && (state_q == IDLE) && !done_q && ({1'b0, ld_addr} < DEPTH_L);
  assign len_sat = (len > DEPTH_L) ? DEPTH_L : len;

  mac_operand_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk),
    .rst_n_i   (reset),
    .wr_en_i   (wr_en),
    .wr_sel_i  (ld_sel),
    .wr_addr_i (ld_addr),
    .wr_data_i (ld_data),
    .rd_idx_i  (idx_q[AW-1:0]),
    .rd_a_o    (rd_a),
    .rd_b_o    (rd_b)
  );

`ifdef MAC_FEEDER_ZERO_SKIP_EN
  assign elem_ok = (rd_a != '0) && (rd_b != '0);
`else
  assign elem_ok = 1'b1;
`endif

  // CLR and STREAM share the presentation step so element 0 appears right after CLR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      drain_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      mac_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      mac_clr_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q     <= len_sat;
            idx_q     <= '0;
            mac_clr_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= CLR;
          end
        end
        CLR, STREAM: begin
          if (idx_q < len_q) begin
            if (elem_ok) begin
              a_q     <= rd_a;
              b_q     <= rd_b;
              valid_q <= 1'b1;
            end
            idx_q   <= idx_q + 1'b1;
            state_q <= STREAM;
          end else begin
            drain_q <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign valid_out = valid_q;
  assign mac_clr   = mac_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Scoreboard bench for mac_vector_feeder; the monitor accumulates a*b like the MAC
// and compares against hand-computed dot products when done pulses.
module tb_mac_vector_feeder;

  logic              clk;
  logic              reset;
  logic              ld_en;
  logic              ld_sel;
  logic [3:0]        ld_addr;
  logic signed [7:0] ld_data;
  logic              start;
  logic [4:0]        len;
  logic signed [7:0] a, b;
  logic              valid_out, mac_clr, busy, done;

`ifdef MAC_FEEDER_ZERO_SKIP_EN
  localparam int ZS = 1;
`else
  localparam int ZS = 0;
`endif

  typedef struct {
    int f;
    int vcnt;
    int lat;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   passes   = 0;
  int   spurious = 0;

  mac_vector_feeder #(.DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .len       (len),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .mac_clr   (mac_clr),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit sel, input int addr, input int d);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = 4'(addr);
    ld_data = 8'(d);
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic run(input int l, input int f, input int v, input int lat);
    exp_t e;
    e.f = f; e.vcnt = v; e.lat = lat;
    q.push_back(e);
    start = 1'b1;
    len   = 5'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      check("run_timeout", q.size(), 0);
      q.delete();
    end
    tick();
  endtask

  // Monitor: MAC-like accumulator and per-run observations.
  logic signed [15:0] acc;
  logic signed [15:0] prod;
  int vcnt, cyc, clr_cnt;
  bit armed = 0;

  always @(negedge clk) begin
    if (!reset) begin
      armed = 0;
    end else begin
      if (mac_clr) begin
        if (!armed) clr_cnt = 0;
        clr_cnt++;
        acc = '0; vcnt = 0; cyc = 0; armed = 1;
      end else if (armed) begin
        cyc++;
      end
      if (valid_out) begin
        prod = a * b;
        acc  = acc + prod;
        vcnt++;
      end
      if (done) begin
        if (q.size() == 0) begin
          spurious++;
          $display("FAIL unexpected_done: got done=1 expected done=0");
        end else begin
          exp_t e;
          e = q.pop_front();
          check("f",          int'(acc), e.f);
          check("valid_cnt",  vcnt,      e.vcnt);
          check("done_lat",   cyc,       e.lat);
          check("busy_at_done", int'(busy), 0);
          check("clr_pulses", clr_cnt,   1);
        end
        armed = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; len = '0;
    #2;
    check("reset_outputs", int'({a, b, valid_out, mac_clr, busy, done}), 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Basic dot product 1*5+2*6+3*7+4*8 = 70
    for (int i = 0; i < 4; i++) begin
      load(1'b0, i, i + 1);
      load(1'b1, i, i + 5);
    end
    run(4, 70, 4, 7);
    wait_done();

    // Signed extremes
    load(1'b0, 0, -128); load(1'b1, 0, -128);
    load(1'b0, 1, 127);  load(1'b1, 1, 127);
    run(2, 32513, 2, 5);
    wait_done();

    // Zero-length run
    run(0, 0, 0, 3);
    wait_done();

    // len=31 saturates to 16: sum of (i+1) for i=0..15 = 136
    for (int i = 0; i < 16; i++) begin
      load(1'b0, i, 1);
      load(1'b1, i, i + 1);
    end
    run(31, 136, 16, 19);
    wait_done();

    // start and ld_en while busy are ignored
    for (int i = 0; i < 4; i++) begin
      load(1'b0, i, i + 1);
      load(1'b1, i, i + 5);
    end
    run(4, 70, 4, 7);
    ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 8'sd99;
    start = 1'b1; len = 5'd2;
    tick(); tick(); tick();
    ld_en = 1'b0; start = 1'b0;
    wait_done();
    run(4, 70, 4, 7);
    wait_done();

    // Zero operands: 3*4 + 2*6 = 24
    load(1'b0, 0, 0); load(1'b1, 0, 9);
    load(1'b0, 1, 3); load(1'b1, 1, 4);
    load(1'b0, 2, 0); load(1'b1, 2, 5);
    load(1'b0, 3, 2); load(1'b1, 3, 6);
    run(4, 24, (ZS != 0) ? 2 : 4, 7);
    wait_done();

    // Reset after E2 abandons the run
    start = 1'b1; len = 5'd4;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("midrun_reset_outputs", int'({a, b, valid_out, mac_clr, busy, done}), 0);
    tick(); tick();
    reset = 1'b1;
    repeat (12) tick();

    // Store was cleared by reset
    run(4, 0, (ZS != 0) ? 0 : 4, 7);
    wait_done();

    check("spurious_done", spurious, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
